// File: rtl/rgb_frame_server.sv
// rgb_frame_server: one-frame RGB store, loaded by the host, read by the LBP engine.
// Define RGB_SERVE_CNT_EN to add the serve_cnt accepted-request counter output.
module rgb_frame_server #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 24,
    parameter int DEPTH  = 16384
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_ready,
    input  logic              frame_start,
    input  logic              RGB_req,
    input  logic [ADDR_W-1:0] RGB_addr,
    output logic              RGB_ready,
    output logic [DATA_W-1:0] RGB_data,
    output logic              RGB_valid,
    output logic              addr_err,
    input  logic              finish
`ifdef RGB_SERVE_CNT_EN
    ,
    output logic [ADDR_W:0]   serve_cnt
`endif
);

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_SERVE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_C  = ADDR_W'(DEPTH - 1);

    state_t state_q, state_d;

    logic [ADDR_W-1:0] wr_cnt_q, wr_cnt_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;

    logic [DATA_W-1:0] mem [DEPTH];

    logic load_fire;
    logic last_beat;
    logic req_fire;
    logic in_range;
    logic enter_load;

    assign load_fire  = load_valid & load_ready;
    assign last_beat  = load_fire && (wr_cnt_q == LAST_C);
    assign req_fire   = RGB_req & RGB_ready;
    assign in_range   = ({1'b0, RGB_addr} < DEPTH_C);
    assign enter_load = (state_q == S_DONE) && frame_start;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_LOAD:  if (last_beat)   state_d = S_SERVE;
            S_SERVE: if (finish)      state_d = S_DONE;
            S_DONE:  if (frame_start) state_d = S_LOAD;
            default:                  state_d = S_LOAD;
        endcase
    end

    always_comb begin
        load_ready = (state_q == S_LOAD);
        RGB_ready  = (state_q == S_SERVE);
    end

    // Frame storage is never reset; a new frame always overwrites every word.
    always_ff @(posedge clk) begin
        if (load_fire) begin
            mem[wr_cnt_q] <= load_data;
        end
    end

    always_comb begin
        wr_cnt_d = wr_cnt_q;
        if (enter_load || last_beat) begin
            wr_cnt_d = '0;
        end else if (load_fire) begin
            wr_cnt_d = wr_cnt_q + 1'b1;
        end
    end

    always_comb begin
        data_d  = data_q;
        valid_d = 1'b0;
        err_d   = err_q;
        if (enter_load) begin
            err_d = 1'b0;
        end
        if (req_fire) begin
            valid_d = 1'b1;
            if (in_range) begin
                data_d = mem[RGB_addr];
            end else begin
                data_d = '0;
                err_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_cnt_q <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            wr_cnt_q <= wr_cnt_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end
    end

    assign RGB_data  = data_q;
    assign RGB_valid = valid_q;
    assign addr_err  = err_q;

`ifdef RGB_SERVE_CNT_EN
    logic [ADDR_W:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (enter_load) begin
            cnt_d = '0;
        end else if (req_fire && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign serve_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_rgb_frame_server.sv
// Scoreboarded bench for rgb_frame_server: full-size frame instance plus a
// DEPTH=1000 instance for out-of-range reads.
module tb_rgb_frame_server;

    localparam int AW = 14;
    localparam int DW = 24;
    localparam int N  = 16384;
    localparam int NS = 1000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic          load_valid, frame_start, RGB_req, finish;
    logic [DW-1:0] load_data;
    logic [AW-1:0] RGB_addr;
    logic          load_ready, RGB_ready, RGB_valid, addr_err;
    logic [DW-1:0] RGB_data;

    logic          s_load_valid, s_frame_start, s_RGB_req, s_finish;
    logic [DW-1:0] s_load_data;
    logic [AW-1:0] s_RGB_addr;
    logic          s_load_ready, s_RGB_ready, s_RGB_valid, s_addr_err;
    logic [DW-1:0] s_RGB_data;

`ifdef RGB_SERVE_CNT_EN
    logic [AW:0] serve_cnt, s_serve_cnt;
`endif

    rgb_frame_server #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(N)) dut (
        .clk(clk), .reset(reset),
        .load_valid(load_valid), .load_data(load_data),
        .load_ready(load_ready), .frame_start(frame_start),
        .RGB_req(RGB_req), .RGB_addr(RGB_addr),
        .RGB_ready(RGB_ready), .RGB_data(RGB_data),
        .RGB_valid(RGB_valid), .addr_err(addr_err),
        .finish(finish)
`ifdef RGB_SERVE_CNT_EN
        , .serve_cnt(serve_cnt)
`endif
    );

    rgb_frame_server #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(NS)) dut_s (
        .clk(clk), .reset(reset),
        .load_valid(s_load_valid), .load_data(s_load_data),
        .load_ready(s_load_ready), .frame_start(s_frame_start),
        .RGB_req(s_RGB_req), .RGB_addr(s_RGB_addr),
        .RGB_ready(s_RGB_ready), .RGB_data(s_RGB_data),
        .RGB_valid(s_RGB_valid), .addr_err(s_addr_err),
        .finish(s_finish)
`ifdef RGB_SERVE_CNT_EN
        , .serve_cnt(s_serve_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] sb  [$];
    logic [DW-1:0] sb2 [$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitors: pop one expected value per presented response.
    always @(negedge clk) begin
        if (RGB_valid) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL main_unexpected_valid: got data %0h, none expected",
                         RGB_data);
            end else begin
                logic [DW-1:0] e;
                e = sb.pop_front();
                if (RGB_data !== e) begin
                    errors++;
                    $display("FAIL main_rdata: got %0h expected %0h", RGB_data, e);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (s_RGB_valid) begin
            checks++;
            if (sb2.size() == 0) begin
                errors++;
                $display("FAIL small_unexpected_valid: got data %0h, none expected",
                         s_RGB_data);
            end else begin
                logic [DW-1:0] e;
                e = sb2.pop_front();
                if (s_RGB_data !== e) begin
                    errors++;
                    $display("FAIL small_rdata: got %0h expected %0h", s_RGB_data, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_frame(input int n, input int mul, input int add,
                              input bit full);
        for (int i = 0; i < n; i++) begin
            load_valid = 1'b1;
            load_data  = DW'(i * mul + add);
            if (full && i == n - 1) begin
                chk("ready_before_last", {31'b0, RGB_ready}, 32'd0);
                chk("load_ready_last", {31'b0, load_ready}, 32'd1);
            end
            tick();
        end
        load_valid = 1'b0;
        if (full) begin
            chk("rgb_ready_after_last", {31'b0, RGB_ready}, 32'd1);
            chk("load_ready_after_last", {31'b0, load_ready}, 32'd0);
        end
    endtask

    task automatic req(input int a, input int exp);
        RGB_req  = 1'b1;
        RGB_addr = AW'(a);
        sb.push_back(DW'(exp));
        tick();
        chk("req_latency_valid", {31'b0, RGB_valid}, 32'd1);
    endtask

    task automatic sreq(input int a, input int exp);
        s_RGB_req  = 1'b1;
        s_RGB_addr = AW'(a);
        sb2.push_back(DW'(exp));
        tick();
        chk("sreq_latency_valid", {31'b0, s_RGB_valid}, 32'd1);
    endtask

    initial begin
        reset = 1'b0;
        {load_valid, frame_start, RGB_req, finish} = '0;
        load_data = '0;
        RGB_addr  = '0;
        {s_load_valid, s_frame_start, s_RGB_req, s_finish} = '0;
        s_load_data = '0;
        s_RGB_addr  = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_load_ready", {31'b0, load_ready}, 32'd1);
        chk("rst_rgb_ready", {31'b0, RGB_ready}, 32'd0);
        chk("rst_rgb_data", 32'(RGB_data), 32'd0);
        chk("rst_rgb_valid", {31'b0, RGB_valid}, 32'd0);
        chk("rst_addr_err", {31'b0, addr_err}, 32'd0);
        tick();
        reset = 1'b1;
        tick();

        // Requests during LOAD are ignored.
        RGB_req  = 1'b1;
        RGB_addr = AW'(5);
        tick();
        RGB_req = 1'b0;
        chk("load_req_valid", {31'b0, RGB_valid}, 32'd0);
        chk("load_req_data", 32'(RGB_data), 32'd0);

        load_frame(N, 3, 0, 1'b1);

        req(0, 0);
        req(1, 3);
        req(N - 1, 49149);
        RGB_req = 1'b0;
        tick();
        chk("idle_valid", {31'b0, RGB_valid}, 32'd0);

        // Host writes and frame_start in SERVE must not disturb anything.
        load_valid  = 1'b1;
        load_data   = 24'hABCDEF;
        frame_start = 1'b1;
        tick();
        load_valid  = 1'b0;
        frame_start = 1'b0;
        chk("serve_ready_hold", {31'b0, RGB_ready}, 32'd1);
        req(0, 0);
        RGB_req = 1'b0;
        tick();

        finish = 1'b1;
        req(7, 21);
        finish  = 1'b0;
        RGB_req = 1'b0;
        chk("finish_ready_low", {31'b0, RGB_ready}, 32'd0);
        chk("finish_load_ready", {31'b0, load_ready}, 32'd0);
        tick();
        RGB_req  = 1'b1;
        RGB_addr = AW'(2);
        tick();
        RGB_req = 1'b0;
        chk("done_req_ignored", {31'b0, RGB_valid}, 32'd0);
        chk("done_data_held", 32'(RGB_data), 32'd21);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("restart_load_ready", {31'b0, load_ready}, 32'd1);
        chk("restart_addr_err", {31'b0, addr_err}, 32'd0);
        chk("restart_rgb_ready", {31'b0, RGB_ready}, 32'd0);

        load_frame(100, 7, 1, 1'b0);
        reset = 1'b0;
        tick();
        chk("midload_rst_ready", {31'b0, load_ready}, 32'd1);
        chk("midload_rst_valid", {31'b0, RGB_valid}, 32'd0);
        reset = 1'b1;
        tick();
        load_frame(N, 5, 7, 1'b1);
        req(0, 7);
        req(100, 507);
        req(N - 1, 81922);
        RGB_req = 1'b0;
        tick();
`ifdef RGB_SERVE_CNT_EN
        chk("main_serve_cnt", 32'(serve_cnt), 32'd3);
`endif

        for (int i = 0; i < NS; i++) begin
            s_load_valid = 1'b1;
            s_load_data  = DW'(i + 1);
            tick();
        end
        s_load_valid = 1'b0;
        chk("small_ready", {31'b0, s_RGB_ready}, 32'd1);
        chk("small_err_init", {31'b0, s_addr_err}, 32'd0);
        sreq(NS, 0);
        chk("small_err_set", {31'b0, s_addr_err}, 32'd1);
        sreq(NS - 1, NS);
        sreq(5, 6);
        s_RGB_req = 1'b0;
        tick();
        chk("small_err_sticky", {31'b0, s_addr_err}, 32'd1);
`ifdef RGB_SERVE_CNT_EN
        chk("small_serve_cnt", 32'(s_serve_cnt), 32'd3);
`endif

        repeat (3) tick();
        chk("sb_main_drained", 32'(sb.size()), 32'd0);
        chk("sb_small_drained", 32'(sb2.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
